rv32i_imem_arb: RTL and testbench

RV32I_IMEM_ARB -- requirements
Module: rv32i_imem_arb

---
 rtl/rv32i_imem_arb.sv | 108 ++++++++++
 tb/tb_rv32i_imem_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rv32i_imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_imem_arb
// Brief    : Single-port instruction-RAM arbiter between instruction fetch and
//            data loads, with fetch anti-starvation and load error checking.
// Revision : 1.0
// ============================================================================
module rv32i_imem_arb #(
    parameter int STARVE_MAX = 2,
    parameter int AW         = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [31:0]   if_rdata,
    input  logic          ld_req,
    input  logic [31:0]   ld_addr,
    input  logic [2:0]    ld_funct3,
    output logic          ld_gnt,
    output logic          ld_valid,
    output logic [31:0]   ld_rdata,
    output logic          ld_err,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        LD_RD  = 2'd2,
        LD_ERR = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_nxt;
    logic          w_fetch_win;
    logic          w_ld_win;
    logic          w_ld_bad;
    logic          w_unused;

    // Byte address bits below the word and above the RAM are not decoded for fetches.
    assign w_unused = ^{if_addr[31:AW+2], if_addr[1:0]};

    always_comb begin
        w_ld_bad = 1'b0;
        case (ld_funct3)
            3'b000, 3'b100: w_ld_bad = 1'b0;
            3'b001, 3'b101: w_ld_bad = ld_addr[0];
            3'b010:         w_ld_bad = |ld_addr[1:0];
            default:        w_ld_bad = 1'b1;
        endcase
        w_ld_bad = w_ld_bad | (|ld_addr[31:15]);
    end

    // Loads win unless the fetch has already lost STARVE_MAX times in a row.
    assign w_fetch_win = !rst && if_req && (!ld_req || (r_starve_cnt == C_STARVE_MAX));
    assign w_ld_win    = !rst && ld_req && !w_fetch_win;

    always_comb begin
        w_state_nxt  = IDLE;
        w_starve_nxt = r_starve_cnt;
        if (w_fetch_win) begin
            w_state_nxt = IF_RD;
        end else if (w_ld_win) begin
            w_state_nxt = w_ld_bad ? LD_ERR : LD_RD;
        end
        if (!if_req || w_fetch_win) begin
            w_starve_nxt = '0;
        end else if (w_ld_win && (r_starve_cnt != C_STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign if_gnt   = w_fetch_win;
    assign ld_gnt   = w_ld_win;
    assign mem_en   = w_fetch_win || (w_ld_win && !w_ld_bad);
    assign mem_addr = w_fetch_win              ? if_addr[AW+1:2] :
                      (w_ld_win && !w_ld_bad)  ? ld_addr[AW+1:2] : '0;

    // A flushed fetch still lets the RAM read finish; only the valid is suppressed.
    assign if_valid = (r_state == IF_RD) && !if_flush;
    assign if_rdata = (r_state == IF_RD) ? mem_rdata : 32'h0;
    assign ld_valid = (r_state == LD_RD) || (r_state == LD_ERR);
    assign ld_err   = (r_state == LD_ERR);
    assign ld_rdata = (r_state == LD_RD) ? mem_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_imem_arb.sv
`default_nettype none
// Testbench for rv32i_imem_arb: randomized traffic against a transaction-level
// reference model, plus a directed contention-order check.
module tb_rv32i_imem_arb;

    localparam int STARVE_MAX = 2;
    localparam int AW         = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, ld_req;
    logic [31:0]   if_addr, ld_addr;
    logic [2:0]    ld_funct3;
    logic          if_gnt, if_valid, ld_gnt, ld_valid, ld_err, mem_en;
    logic [31:0]   if_rdata, ld_rdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_vec = 0;
    int n_err = 0;

    // Model state: kind of response due this cycle (0 none, 1 fetch, 2 load, 3 load error)
    int          resp_kind = 0;
    logic [31:0] resp_word = 0;
    int          starve    = 0;
    bit          last_fetch, last_load;
    logic        dut_if_gnt;

    rv32i_imem_arb #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] widx);
        return (widx * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // RAM stand-in: garbage on the read bus whenever no read was issued.
    always @(posedge clk) mem_rdata <= mem_en ? ram_word(32'(mem_addr)) : $urandom();

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit load_is_bad(input logic [31:0] a, input logic [2:0] f);
        int size;
        case (f)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) return 1'b1;
        if (a >= 32'h8000) return 1'b1;
        return (a % size) != 0;
    endfunction

    // Check one cycle of outputs against the model, then advance past the next edge.
    task automatic run_cycle();
        bit          fw, lw, bad;
        int          nk;
        logic [31:0] nword, e_addr;
        #3;
        dut_if_gnt = if_gnt;
        nk = 0; nword = 0; fw = 0; lw = 0;
        if (rst) begin
            check("rst_ctl", {26'h0, if_gnt, ld_gnt, mem_en, if_valid, ld_valid, ld_err}, 32'h0);
            check("rst_mem_addr", 32'(mem_addr), 32'h0);
            check("rst_if_rdata", if_rdata, 32'h0);
            check("rst_ld_rdata", ld_rdata, 32'h0);
            starve = 0;
        end else begin
            fw  = if_req && (!ld_req || starve >= STARVE_MAX);
            lw  = ld_req && !fw;
            bad = lw && load_is_bad(ld_addr, ld_funct3);
            e_addr = fw ? (if_addr >> 2) : (lw && !bad) ? (ld_addr >> 2) : 32'h0;
            e_addr = e_addr & ((32'h1 << AW) - 1);
            check("if_gnt", {31'h0, if_gnt}, {31'h0, fw});
            check("ld_gnt", {31'h0, ld_gnt}, {31'h0, lw});
            check("mem_en", {31'h0, mem_en}, {31'h0, fw || (lw && !bad)});
            check("mem_addr", 32'(mem_addr), e_addr);
            check("if_valid", {31'h0, if_valid}, {31'h0, resp_kind == 1 && !if_flush});
            check("if_rdata", if_rdata, resp_kind == 1 ? resp_word : 32'h0);
            check("ld_valid", {31'h0, ld_valid}, {31'h0, resp_kind >= 2});
            check("ld_err", {31'h0, ld_err}, {31'h0, resp_kind == 3});
            check("ld_rdata", ld_rdata, resp_kind == 2 ? resp_word : 32'h0);
            if (fw) begin nk = 1; nword = ram_word(e_addr); end
            else if (lw) begin nk = bad ? 3 : 2; nword = bad ? 32'h0 : ram_word(e_addr); end
            if (!if_req || fw) starve = 0;
            else if (lw && starve < STARVE_MAX) starve++;
        end
        last_fetch = fw;
        last_load  = lw;
        @(posedge clk);
        #1;
        resp_kind = nk;
        resp_word = nword;
    endtask

    task automatic new_fetch();
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 32'h7FFF));
    endtask

    task automatic new_load();
        logic [2:0] codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        ld_req    = ($urandom_range(0, 2) != 0);
        ld_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : codes[$urandom_range(0, 4)];
        ld_addr   = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 32'h7FFF));
        if ($urandom_range(0, 1) == 0) ld_addr[1:0] = 2'b00;
    endtask

    logic [5:0] order;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        ld_req = 0; ld_addr = 0; ld_funct3 = 0;
        #1;
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Contention with good word loads: expected order LD, LD, IF, LD, LD, IF.
        if_req = 1; if_addr = 32'h10; ld_req = 1; ld_funct3 = 3'b010; ld_addr = 32'h100;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            order[i] = dut_if_gnt;
            ld_addr  = ld_addr + 32'h4;
        end
        check("contention_order", {26'h0, order}, 32'h24);
        if_req = 0; ld_req = 0;
        run_cycle();

        // Randomized traffic with flushes and occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                resp_kind = 0;
                starve = 0;
            end
            if (last_fetch || !if_req) new_fetch();
            if (last_load || !ld_req) new_load();
            if_flush = ($urandom_range(0, 7) == 0);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
